// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops len words from a show-ahead FIFO read port and replays them as a
// valid/ready stream with a last marker and a done pulse. Define FIFO_BURST_TIMEOUT_EN for abort-on-empty.
module fifo_burst_reader #(
  parameter int DATESIZE = 8,
  parameter int LENSIZE  = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic                rclk,
  input  logic                r_rst,
  input  logic                start,
  input  logic [LENSIZE-1:0]  len,
  input  logic [DATESIZE-1:0] rdata,
  input  logic                rempty,
  input  logic                almost_empty,
  output logic                rinc,
  output logic [DATESIZE-1:0] m_data,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                busy,
  output logic                done,
  output logic                low_water
`ifdef FIFO_BURST_TIMEOUT_EN
  ,
  output logic                err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [LENSIZE-1:0] rem_r;
  logic               pop_s;
  logic               accept_s;
  logic               tmo_hit_s;
  logic               trunc_s;

  assign accept_s = (state_r == IDLE) & start;
  assign pop_s    = (state_r == RUN) & ~rempty & (rem_r != {LENSIZE{1'b0}})
                    & (~m_valid | m_ready) & ~r_rst;
  assign rinc     = pop_s;

`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  assign tmo_hit_s = (state_r == RUN) & rempty & (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
  assign trunc_s   = err;

  // Consecutive-empty counter; any pop or leaving RUN restarts it.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r != RUN) || pop_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (rempty) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  // Sticky abort flag, cleared by the next accepted start.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      err <= 1'b0;
    end else if (accept_s) begin
      err <= 1'b0;
    end else if (tmo_hit_s) begin
      err <= 1'b1;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign trunc_s   = 1'b0;
`endif

  // State register.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len != {LENSIZE{1'b0}}) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // An abort while the pending word is being accepted has nothing left to flush.
        if (tmo_hit_s) begin
          if (m_valid & ~m_ready) begin
            state_s = FLUSH;
          end else begin
            state_s = DONE;
          end
        end else if (pop_s && (rem_r == LENSIZE'(1))) begin
          state_s = FLUSH;
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (m_valid & m_ready & (m_last | trunc_s)) begin
          state_s = DONE;
        end else begin
          state_s = FLUSH;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Remaining-word counter.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      rem_r <= {LENSIZE{1'b0}};
    end else if (accept_s) begin
      rem_r <= len;
    end else if (tmo_hit_s) begin
      rem_r <= {LENSIZE{1'b0}};
    end else if (pop_s) begin
      rem_r <= rem_r - LENSIZE'(1);
    end
  end

  // Output stream register: load on pop, drain on handshake, hold under backpressure.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      m_data  <= {DATESIZE{1'b0}};
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (pop_s) begin
      m_data  <= rdata;
      m_valid <= 1'b1;
      m_last  <= (rem_r == LENSIZE'(1));
    end else if (m_valid & m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

  // Registered status outputs.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      low_water <= 1'b0;
    end else begin
      busy      <= (state_s != IDLE);
      done      <= (state_s == DONE);
      low_water <= almost_empty;
    end
  end

endmodule
